// File: rtl/nco_clock_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators with
// runtime increments. All channels restart together after every reconfiguration.
module nco_lane #(
  parameter int ACC_W = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [ACC_W-1:0] load_inc,
  output logic             ce,
  output logic             msb
);
  logic [ACC_W-1:0] inc, acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};
  assign msb = acc[ACC_W-1];

  always_ff @(posedge clk_in) begin
    if (rst) begin
      inc <= INC_RST;
      acc <= '0;
      ce  <= 1'b0;
    end else begin
      if (load) inc <= load_inc;
      // Holding acc at zero outside RUN is what phase-aligns every lane on relock.
      if (run) begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end else begin
        acc <= '0;
        ce  <= 1'b0;
      end
    end
  end
endmodule

module nco_clock_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = {32'd2233382994, 32'd3092376453},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic {WAIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             xfer, ch_ok, relock, lane_run;

  assign xfer      = cfg_valid && cfg_ready;
  assign ch_ok     = int'(cfg_ch) < NUM_CH;
  assign relock    = xfer && ch_ok;
  assign locked    = (state == RUN);
  assign cfg_ready = (state == RUN);
  assign lane_run  = (state == RUN) && !relock;

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:    if (cnt == CNT_W'(LOCK_CYCLES - 1)) state_nxt = RUN;
      RUN:     if (relock) state_nxt = WAIT;
      default: state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state   <= WAIT;
      cnt     <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= xfer && !ch_ok;
      // Counter idles at zero in RUN so a relock always starts a full settle window.
      if (state == WAIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    nco_lane #(
      .ACC_W   (ACC_W),
      .INC_RST (DEFAULT_INC[g*ACC_W +: ACC_W])
    ) u_lane (
      .clk_in   (clk_in),
      .rst      (rst),
      .run      (lane_run),
      .load     (relock && (cfg_ch == CH_W'(g))),
      .load_inc (cfg_inc),
      .ce       (ce_out[g]),
      .msb      (clk_out[g])
    );
  end
endmodule

// File: tb/tb_nco_clock_gen.sv
// Directed bench for nco_clock_gen: default-parameter lock timing plus a small
// 3-channel 8-bit instance for rates, reconfiguration and corner cases.
module tb_nco_clock_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-parameter instance (lock timing only)
  logic        rst_d = 1'b1;
  logic        d_valid = 1'b0;
  logic        d_ch = 1'b0;
  logic [31:0] d_inc = '0;
  logic        d_ready, d_err, d_locked;
  logic [1:0]  d_ce, d_clk;

  nco_clock_gen dut_def (
    .clk_in(clk), .rst(rst_d), .cfg_valid(d_valid), .cfg_ready(d_ready),
    .cfg_ch(d_ch), .cfg_inc(d_inc), .cfg_err(d_err), .ce_out(d_ce),
    .clk_out(d_clk), .locked(d_locked)
  );

  // Small instance: ch0=32, ch1=64, ch2=0 (stopped)
  logic       rst = 1'b1;
  logic       m_valid = 1'b0;
  logic [1:0] m_ch = '0;
  logic [7:0] m_inc = '0;
  logic       m_ready, m_err, m_locked;
  logic [2:0] m_ce, m_clk;

  nco_clock_gen #(
    .NUM_CH(3), .ACC_W(8), .LOCK_CYCLES(4),
    .DEFAULT_INC({8'd0, 8'd64, 8'd32})
  ) dut (
    .clk_in(clk), .rst(rst), .cfg_valid(m_valid), .cfg_ready(m_ready),
    .cfg_ch(m_ch), .cfg_inc(m_inc), .cfg_err(m_err), .ce_out(m_ce),
    .clk_out(m_clk), .locked(m_locked)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if (d_locked !== 1'b0 || d_ready !== 1'b0 || d_err !== 1'b0 || d_ce !== 2'b0 || d_clk !== 2'b0) begin
      errors++;
      $display("FAIL reset_state: locked=%b ready=%b err=%b ce=%b clk=%b want all 0",
               d_locked, d_ready, d_err, d_ce, d_clk);
    end
    rst_d = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (d_locked !== 1'b0 || d_ready !== 1'b0 || d_ce !== 2'b0) begin
        errors++;
        $display("FAIL prelock_edge%0d: locked=%b ready=%b ce=%b want 0 0 00", k, d_locked, d_ready, d_ce);
      end
    end
    tick();
    checks++;
    if (d_locked !== 1'b1 || d_ready !== 1'b1) begin
      errors++;
      $display("FAIL lock_edge16: locked=%b ready=%b want 1 1", d_locked, d_ready);
    end
  endtask

  // Reset the small instance and wait through its 4-edge lock window.
  task automatic main_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (m_locked !== 1'b0 || m_ready !== 1'b0 || m_err !== 1'b0 || m_ce !== 3'b0 || m_clk !== 3'b0) begin
      errors++;
      $display("FAIL main_reset_state: locked=%b ready=%b err=%b ce=%b clk=%b want all 0",
               m_locked, m_ready, m_err, m_ce, m_clk);
    end
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (m_locked !== (k == 4) || m_ce !== 3'b0) begin
        errors++;
        $display("FAIL main_lock_edge%0d: locked=%b ce=%b want %b 000", k, m_locked, m_ce, k == 4);
      end
    end
  endtask

  // Accept one request, then check the 4-edge relock with all outputs quiet.
  task automatic program_and_relock(input logic [1:0] ch, input logic [7:0] inc, input string name);
    m_valid = 1'b1; m_ch = ch; m_inc = inc;
    tick();
    m_valid = 1'b0;
    checks++;
    if (m_locked !== 1'b0 || m_ready !== 1'b0 || m_ce !== 3'b0 || m_clk !== 3'b0) begin
      errors++;
      $display("FAIL %s_drop: locked=%b ready=%b ce=%b clk=%b want 0 0 000 000",
               name, m_locked, m_ready, m_ce, m_clk);
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (m_locked !== (k == 4) || m_ce !== 3'b0 || m_clk !== 3'b0) begin
        errors++;
        $display("FAIL %s_relock_edge%0d: locked=%b ce=%b clk=%b want %b 000 000",
                 name, k, m_locked, m_ce, m_clk, k == 4);
      end
    end
  endtask

  task automatic test_rates();
    int n0, n1, n2;
    logic [2:0] exp_ce;
    logic       exp_clk1;
    n0 = 0; n1 = 0; n2 = 0;
    main_reset();
    for (int j = 1; j <= 64; j++) begin
      tick();
      exp_ce   = {1'b0, (j % 4) == 0, (j % 8) == 0};
      exp_clk1 = ((j % 4) == 2) || ((j % 4) == 3);
      n0 += int'(m_ce[0]); n1 += int'(m_ce[1]); n2 += int'(m_ce[2]);
      checks++;
      if (m_ce !== exp_ce || m_clk[1] !== exp_clk1 || m_clk[2] !== 1'b0) begin
        errors++;
        $display("FAIL rates_cycle%0d: ce=%b clk=%b want ce=%b clk1=%b clk2=0",
                 j, m_ce, m_clk, exp_ce, exp_clk1);
      end
    end
    checks++;
    if (n0 != 8 || n1 != 16 || n2 != 0) begin
      errors++;
      $display("FAIL rates_counts: ch0=%0d ch1=%0d ch2=%0d want 8 16 0", n0, n1, n2);
    end
  endtask

  task automatic test_reconfig();
    program_and_relock(2'd0, 8'd128, "reconfig");
    for (int j = 1; j <= 16; j++) begin
      tick();
      checks++;
      if (m_ce[0] !== ((j % 2) == 0) || m_ce[1] !== ((j % 4) == 0) || m_locked !== 1'b1) begin
        errors++;
        $display("FAIL reconfig_cycle%0d: ce=%b locked=%b want ce0=%b ce1=%b locked=1",
                 j, m_ce, m_locked, (j % 2) == 0, (j % 4) == 0);
      end
    end
  endtask

  task automatic test_fractional();
    int n;
    logic prev, exp;
    n = 0; prev = 1'b0;
    program_and_relock(2'd0, 8'd96, "frac");
    for (int j = 1; j <= 32; j++) begin
      tick();
      exp = ((96 * j) / 256) != ((96 * (j - 1)) / 256);
      n += int'(m_ce[0]);
      checks++;
      if (m_ce[0] !== exp || (prev && m_ce[0])) begin
        errors++;
        $display("FAIL frac_cycle%0d: ce0=%b prev=%b want %b, no back-to-back", j, m_ce[0], prev, exp);
      end
      prev = m_ce[0];
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL frac_count: got %0d pulses want 12", n);
    end
  endtask

  task automatic test_invalid_ch();
    int n0, n1;
    n0 = 0; n1 = 0;
    m_valid = 1'b1; m_ch = 2'd3; m_inc = 8'd7;
    tick();
    m_valid = 1'b0;
    checks++;
    if (m_err !== 1'b1 || m_locked !== 1'b1) begin
      errors++;
      $display("FAIL invalid_err: err=%b locked=%b want 1 1", m_err, m_locked);
    end
    tick();
    checks++;
    if (m_err !== 1'b0 || m_locked !== 1'b1) begin
      errors++;
      $display("FAIL invalid_pulse_end: err=%b locked=%b want 0 1", m_err, m_locked);
    end
    // Any 32-cycle window holds exactly 12 wraps at inc=96 and 8 at inc=64.
    for (int j = 1; j <= 32; j++) begin
      tick();
      n0 += int'(m_ce[0]); n1 += int'(m_ce[1]);
    end
    checks++;
    if (n0 != 12 || n1 != 8 || m_locked !== 1'b1) begin
      errors++;
      $display("FAIL invalid_rates: ch0=%0d ch1=%0d locked=%b want 12 8 1", n0, n1, m_locked);
    end
  endtask

  task automatic test_back_to_back();
    m_valid = 1'b1; m_ch = 2'd0; m_inc = 8'd128;
    tick();
    m_ch = 2'd1; m_inc = 8'd128;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (m_locked !== (k == 4)) begin
        errors++;
        $display("FAIL b2b_held_edge%0d: locked=%b want %b", k, m_locked, k == 4);
      end
    end
    m_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (m_locked !== (k == 4)) begin
        errors++;
        $display("FAIL b2b_relock_edge%0d: locked=%b want %b", k, m_locked, k == 4);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      tick();
      checks++;
      if (m_ce !== {1'b0, (j % 2) == 0, (j % 2) == 0} || m_locked !== 1'b1) begin
        errors++;
        $display("FAIL b2b_cycle%0d: ce=%b locked=%b want %b 1",
                 j, m_ce, m_locked, {1'b0, (j % 2) == 0, (j % 2) == 0});
      end
    end
  endtask

  task automatic test_inc_max();
    int n;
    n = 0;
    program_and_relock(2'd0, 8'd255, "incmax");
    for (int j = 1; j <= 256; j++) begin
      tick();
      n += int'(m_ce[0]);
    end
    checks++;
    if (n != 255) begin
      errors++;
      $display("FAIL incmax_count: got %0d strobes in 256 cycles want 255", n);
    end
  endtask

  task automatic test_reset_mid_relock();
    m_valid = 1'b1; m_ch = 2'd1; m_inc = 8'd16;
    tick();
    m_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (m_locked !== (k == 4) || m_ce !== 3'b0) begin
        errors++;
        $display("FAIL rstmid_lock_edge%0d: locked=%b ce=%b want %b 000", k, m_locked, m_ce, k == 4);
      end
    end
    for (int j = 1; j <= 16; j++) begin
      tick();
      checks++;
      if (m_ce !== {1'b0, (j % 4) == 0, (j % 8) == 0}) begin
        errors++;
        $display("FAIL rstmid_default_cycle%0d: ce=%b want %b", j, m_ce, {1'b0, (j % 4) == 0, (j % 8) == 0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_rates();
    test_reconfig();
    test_fractional();
    test_invalid_ch();
    test_back_to_back();
    test_inc_max();
    test_reset_mid_relock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
